// File: rtl/vx_pending_pkg.sv
// Shared types and width helpers for the pending-issue gate.
// Optional watermark outputs are enabled in the top by VX_PENDING_GATE_WMARK_EN.
package vx_pending_pkg;

    typedef enum logic [1:0] {
        PG_RUN   = 2'd0,
        PG_DRAIN = 2'd1,
        PG_DONE  = 2'd2
    } pg_state_e;

    // Bits needed to hold any count 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vx_pending_issue_gate_popcount.sv
// Combinational population count of an N-bit lane mask.
module vx_lane_popcount #(
    parameter int N = 4
) (
    input  logic [N-1:0]              bits,
    output logic [$clog2(N+1)-1:0]    count
);
    localparam int W = $clog2(N + 1);

    always_comb begin
        // NOTE: assigning a default before the loop keeps this purely combinational (no latch).
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(bits[i]);
        end
    end

endmodule

// File: rtl/vx_pending_issue_gate.sv
// Issue-side gate: registered incr/decr, shadow outstanding count, issue throttle and flush/drain FSM.
// Define VX_PENDING_GATE_WMARK_EN to add the peak_size / stall_cycles watermark outputs.
module vx_pending_issue_gate
    import vx_pending_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int SIZE      = 16,
    parameter int INCRW     = cnt_width(NUM_LANES),
    parameter int SIZEW     = cnt_width(SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] req_valid,
    output logic                 req_ready,
    input  logic [INCRW-1:0]     rsp_cnt,
    input  logic                 flush,
    output logic [INCRW-1:0]     incr,
    output logic [INCRW-1:0]     decr,
    output logic [SIZEW-1:0]     size,
    output logic                 empty,
    output logic                 full,
    output logic                 drained,
    output logic                 underflow
`ifdef VX_PENDING_GATE_WMARK_EN
    ,
    output logic [SIZEW-1:0]     peak_size,
    output logic [31:0]          stall_cycles
`endif
);
    localparam int AW = SIZEW + 1;

    pg_state_e        state, state_next;
    logic [INCRW-1:0] pop, n_req, rsp_clamp, n_rsp;
    logic [AW-1:0]    avail;
    logic [SIZEW-1:0] size_next;
    logic             fire, rsp_over, uflow_now, drain_done;

    // Throttle depends only on registered state so req_ready never loops back through req_valid.
    assign full      = size > SIZEW'(SIZE - NUM_LANES);
    assign empty     = (size == '0);
    assign req_ready = (state == PG_RUN) && !full;
    assign fire      = (|req_valid) && req_ready;

    vx_lane_popcount #(.N(NUM_LANES)) u_popcount (
        .bits  (req_valid),
        .count (pop)
    );

    always_comb begin
        n_req     = fire ? pop : '0;
        rsp_over  = rsp_cnt > INCRW'(NUM_LANES);
        rsp_clamp = rsp_over ? INCRW'(NUM_LANES) : rsp_cnt;
        avail     = AW'(size) + AW'(n_req);
        n_rsp     = (AW'(rsp_clamp) > avail) ? INCRW'(avail) : rsp_clamp;
        uflow_now = rsp_over || (AW'(rsp_cnt) > avail);
        size_next = SIZEW'(avail - AW'(n_rsp));
    end

    // Drain completes only once nothing is outstanding and no increment is still in flight downstream.
    assign drain_done = (state == PG_DRAIN) && (size == '0) && (incr == '0);

    always_comb begin
        state_next = state;
        unique case (state)
            PG_RUN:   if (flush)      state_next = PG_DRAIN;
            PG_DRAIN: if (drain_done) state_next = PG_DONE;
            PG_DONE:  if (!flush)     state_next = PG_RUN;
            default:                  state_next = PG_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= PG_RUN;
            incr      <= '0;
            decr      <= '0;
            size      <= '0;
            drained   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_next;
            incr      <= n_req;
            decr      <= n_rsp;
            size      <= size_next;
            drained   <= drain_done;
            underflow <= underflow | uflow_now;
        end
    end

`ifdef VX_PENDING_GATE_WMARK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_size    <= '0;
            stall_cycles <= '0;
        end else begin
            if (size_next > peak_size)
                peak_size <= (size_next > SIZEW'(SIZE)) ? SIZEW'(SIZE) : size_next;
            if ((|req_valid) && !req_ready && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vx_pending_issue_gate.sv
// Scoreboard bench for vx_pending_issue_gate: directed scenarios plus randomized traffic against a count model.
module tb_vx_pending_issue_gate;
    localparam int NL = 4;
    localparam int SZ = 16;
    localparam int IW = 3;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NL-1:0] req_valid = '0;
    logic [IW-1:0] rsp_cnt = '0;
    logic          flush = 1'b0;
    logic          req_ready, empty, full, drained, underflow;
    logic [IW-1:0] incr, decr;
    logic [SW-1:0] size;
`ifdef VX_PENDING_GATE_WMARK_EN
    logic [SW-1:0] peak_size;
    logic [31:0]   stall_cycles;
`endif

    vx_pending_issue_gate #(.NUM_LANES(NL), .SIZE(SZ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rsp_cnt   (rsp_cnt),
        .flush     (flush),
        .incr      (incr),
        .decr      (decr),
        .size      (size),
        .empty     (empty),
        .full      (full),
        .drained   (drained),
        .underflow (underflow)
`ifdef VX_PENDING_GATE_WMARK_EN
        ,
        .peak_size    (peak_size),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int     ready;
        int     incr;
        int     decr;
        int     size;
        int     drained;
        int     uf;
        int     peak;
        longint stall;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Reference model: outstanding count plus a mode (0 issuing, 1 draining, 2 drained/held).
    int     m_mode, m_size, m_incr, m_uf, m_peak;
    longint m_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_ready();
        return (m_mode == 0 && m_size + NL <= SZ) ? 1 : 0;
    endfunction

    function automatic void model_clear();
        m_mode = 0; m_size = 0; m_incr = 0; m_uf = 0; m_peak = 0; m_stall = 0;
    endfunction

    task automatic step(input logic [NL-1:0] v, input int r, input bit f);
        int rdy, nreq, reff, avail, nrsp, drn;
        exp_t e;
        @(negedge clk);
        req_valid = v;
        rsp_cnt   = IW'(r);
        flush     = f;
        rdy   = model_ready();
        nreq  = (v != 0 && rdy != 0) ? $countones(v) : 0;
        reff  = (r > NL) ? NL : r;
        avail = m_size + nreq;
        nrsp  = (reff < avail) ? reff : avail;
        if (r > NL || r > avail) m_uf = 1;
        if (v != 0 && rdy == 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
        drn = (m_mode == 1 && m_size == 0 && m_incr == 0) ? 1 : 0;
        case (m_mode)
            0: if (f) m_mode = 1;
            1: if (drn != 0) m_mode = 2;
            default: if (!f) m_mode = 0;
        endcase
        m_size = avail - nrsp;
        m_incr = nreq;
        if (m_size > m_peak) m_peak = m_size;
        e.ready = model_ready(); e.incr = nreq; e.decr = nrsp; e.size = m_size;
        e.drained = drn; e.uf = m_uf; e.peak = m_peak; e.stall = m_stall;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        req_valid = '0; rsp_cnt = '0; flush = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_incr", incr, 0);
        check("rst_decr", decr, 0);
        check("rst_size", size, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_drained", drained, 0);
        check("rst_underflow", underflow, 0);
`ifdef VX_PENDING_GATE_WMARK_EN
        check("rst_peak", peak_size, 0);
        check("rst_stall", stall_cycles, 0);
`endif
        model_clear();
        q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: registered outputs settle just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("req_ready", req_ready, e.ready);
                check("incr", incr, e.incr);
                check("decr", decr, e.decr);
                check("size", size, e.size);
                check("empty", empty, (e.size == 0) ? 1 : 0);
                check("full", full, (e.size + NL > SZ) ? 1 : 0);
                check("drained", drained, e.drained);
                check("underflow", underflow, e.uf);
                check("size_bound", (size <= SZ) ? 1 : 0, 1);
`ifdef VX_PENDING_GATE_WMARK_EN
                check("peak_size", peak_size, e.peak);
                check("stall_cycles", stall_cycles, e.stall);
`endif
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit hold_flush;
        int r;
        model_clear();
        do_reset();

        // Fill from empty: batches accepted until no room for another full batch.
        repeat (6) step(4'b1111, 0, 0);
        step(4'b0000, 4, 0);
        step(4'b0000, 4, 0);
        // Concurrent issue and retire.
        step(4'b0101, 3, 0);
        step(4'b0000, 2, 0);
        // Flush with a batch firing the same cycle, then drain to zero.
        step(4'b0011, 0, 1);
        step(4'b1111, 3, 1);
        step(4'b0000, 4, 1);
        step(4'b0000, 0, 1);
        step(4'b0000, 0, 1);
        step(4'b0000, 0, 0);
        step(4'b0001, 0, 0);
        // Flush when already empty.
        step(4'b0000, 1, 0);
        step(4'b0000, 0, 1);
        step(4'b0000, 0, 0);
        step(4'b0000, 0, 0);
        // Underflow, stickiness and out-of-range clamp.
        step(4'b0001, 0, 0);
        step(4'b0000, 3, 0);
        step(4'b0000, 0, 0);
        step(4'b1111, 7, 0);
        step(4'b0010, 0, 0);
        // Reset while draining.
        step(4'b1111, 0, 0);
        step(4'b0000, 0, 1);
        step(4'b0000, 1, 1);
        do_reset();
        step(4'b0110, 0, 0);
        step(4'b0000, 2, 0);

        for (int blk = 0; blk < 4; blk++) begin
            hold_flush = 1'b0;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 19) == 0) hold_flush = ~hold_flush;
                if ($urandom_range(0, 49) == 0)
                    r = $urandom_range(0, 7);
                else
                    r = $urandom_range(0, (m_size < NL) ? m_size : NL);
                step(NL'($urandom_range(0, 15)), r, hold_flush);
            end
            do_reset();
        end

        step(4'b0000, 0, 0);
        @(posedge clk);
        #2;
        check("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
